// File: rtl/vec_int_ctrl.sv
// rtl/vec_int_ctrl.sv - vectored interrupt controller: sync, edge/level trigger, mask, priority, EPC capture
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   irq_in      raw asynchronous request lines, one per channel
//   mask_we     mask register write strobe
//   mask_wdata  new mask value (1 = channel enabled)
//   int_take    one-cycle pulse: control FSM enters its interrupt state
//   epc_in      current PC, captured when int_take is accepted
//   rfe         one-cycle pulse: return-from-exception executed
//   int_req     interrupt request to the control FSM
//   int_vector  handler address of the granted channel
//   active_ch   granted channel index
//   epc_out     saved return PC
//   in_service  handler running, global enable cleared
//   mask_q      current mask register
//   pending_q   current pending bits
module vec_int_ctrl #(
    parameter int                N_CH        = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE    = 'h100,
    parameter int                VEC_STRIDE  = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [N_CH-1:0]   EDGE_MASK   = '1,
    parameter bit                PRIO_RR     = 1'b0,
    parameter logic [N_CH-1:0]   MASK_RST    = '1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_CH-1:0]                           irq_in,
    input  logic                                      mask_we,
    input  logic [N_CH-1:0]                           mask_wdata,
    input  logic                                      int_take,
    input  logic [ADDR_W-1:0]                         epc_in,
    input  logic                                      rfe,
    output logic                                      int_req,
    output logic [ADDR_W-1:0]                         int_vector,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] active_ch,
    output logic [ADDR_W-1:0]                         epc_out,
    output logic                                      in_service,
    output logic [N_CH-1:0]                           mask_q,
    output logic [N_CH-1:0]                           pending_q
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERVICE
    } state_t;

    state_t          state;
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] prev_q;
    logic            gie;
    logic [CH_W-1:0] rr_ptr;

    logic [N_CH-1:0] sync_lvl;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] pending_d;
    logic [N_CH-1:0] eligible;
    logic            take_ok;
    logic            rfe_ok;
    logic            win_found;
    logic [CH_W-1:0] win_idx;
    logic [CH_W-1:0] next_ptr;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_q;
    assign take_ok  = (state == ST_PEND) && int_take;
    assign rfe_ok   = (state == ST_SERVICE) && rfe;
    assign eligible = pending_q & mask_q & {N_CH{gie}};

    // Only edge channels are cleared by the block; level channels follow the line.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = take_ok && (active_ch == CH_W'(i)) && EDGE_MASK[i];
        end
    end

    // A new edge in the same cycle as the clear keeps the bit set so the
    // second request is not lost.
    assign pending_d = (EDGE_MASK & (rise | (pending_q & ~clr)))
                     | (~EDGE_MASK & sync_lvl);

    // Winner search: start at channel 0 (fixed) or at rr_ptr (round-robin),
    // walk upward with wrap, take the first eligible channel.
    always_comb begin : p_win
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PRIO_RR ? ((int'(rr_ptr) + k) % N_CH) : k;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(idx);
            end
        end
    end

    assign next_ptr = (active_ch == CH_W'(N_CH - 1)) ? '0 : active_ch + CH_W'(1);

    // Synchroniser chain, edge-detect history, pending and mask registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q    <= sync_lvl;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Request/service FSM. All outputs are registered here; once a request
    // is raised it stays frozen until the control FSM takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            gie        <= 1'b1;
            rr_ptr     <= '0;
            int_req    <= 1'b0;
            int_vector <= VEC_BASE;
            active_ch  <= '0;
            epc_out    <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        active_ch  <= win_idx;
                        int_vector <= VEC_BASE + ADDR_W'(win_idx) * ADDR_W'(VEC_STRIDE);
                        int_req    <= 1'b1;
                        state      <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (take_ok) begin
                        epc_out    <= epc_in;
                        gie        <= 1'b0;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (rfe_ok) begin
                        gie        <= 1'b1;
                        in_service <= 1'b0;
                        rr_ptr     <= next_ptr;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// tb/tb_vec_int_ctrl.sv - randomized and directed checks of vec_int_ctrl against a behavioural model
module tb_vec_int_ctrl;

    localparam int            N      = 4;
    localparam int            AW     = 32;
    localparam int            S      = 2;
    localparam logic [AW-1:0] BASE   = 32'h100;
    localparam int            STRIDE = 16;
    localparam int            IDLE   = 0;
    localparam int            PEND   = 1;
    localparam int            SVC    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  irq        [2];
    logic          mask_we    [2];
    logic [N-1:0]  mask_wdata [2];
    logic          int_take   [2];
    logic [AW-1:0] epc_in     [2];
    logic          rfe        [2];
    logic          int_req    [2];
    logic [AW-1:0] int_vector [2];
    logic [1:0]    active_ch  [2];
    logic [AW-1:0] epc_out    [2];
    logic          in_service [2];
    logic [N-1:0]  mask_q     [2];
    logic [N-1:0]  pending_q  [2];

    // dut 0: defaults (all edge, fixed priority); dut 1: all level, round-robin
    vec_int_ctrl u_fix (
        .clk(clk), .rst(rst), .irq_in(irq[0]), .mask_we(mask_we[0]), .mask_wdata(mask_wdata[0]),
        .int_take(int_take[0]), .epc_in(epc_in[0]), .rfe(rfe[0]), .int_req(int_req[0]),
        .int_vector(int_vector[0]), .active_ch(active_ch[0]), .epc_out(epc_out[0]),
        .in_service(in_service[0]), .mask_q(mask_q[0]), .pending_q(pending_q[0])
    );

    vec_int_ctrl #(.PRIO_RR(1'b1), .EDGE_MASK(4'b0000)) u_rr (
        .clk(clk), .rst(rst), .irq_in(irq[1]), .mask_we(mask_we[1]), .mask_wdata(mask_wdata[1]),
        .int_take(int_take[1]), .epc_in(epc_in[1]), .rfe(rfe[1]), .int_req(int_req[1]),
        .int_vector(int_vector[1]), .active_ch(active_ch[1]), .epc_out(epc_out[1]),
        .in_service(in_service[1]), .mask_q(mask_q[1]), .pending_q(pending_q[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    logic [N-1:0]  edge_m [2] = '{4'b1111, 4'b0000};
    bit            rr_m   [2] = '{1'b0, 1'b1};
    logic [N-1:0]  m_hist [2][S+1];   // m_hist[d][j] = irq sampled j+1 edges ago
    logic [N-1:0]  m_pend [2];
    logic [N-1:0]  m_mask [2];
    int            m_state[2];
    bit            m_gie  [2];
    int            m_act  [2];
    int            m_ptr  [2];
    bit            m_req  [2];
    logic [AW-1:0] m_vec  [2];
    logic [AW-1:0] m_epc  [2];
    bit            m_insvc[2];

    function automatic int pick(input int d, input logic [N-1:0] elig);
        for (int k = 0; k < N; k++) begin
            int c;
            c = rr_m[d] ? (m_ptr[d] + k) % N : k;
            if (elig[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset(input int d);
        for (int j = 0; j <= S; j++) m_hist[d][j] = '0;
        m_pend[d] = '0; m_mask[d] = 4'b1111; m_state[d] = IDLE; m_gie[d] = 1'b1;
        m_act[d] = 0; m_ptr[d] = 0; m_req[d] = 1'b0; m_vec[d] = BASE;
        m_epc[d] = '0; m_insvc[d] = 1'b0;
    endtask

    task automatic model_step(input int d);
        logic [N-1:0] lvl, rise, elig, np;
        bit take_ok;
        lvl     = m_hist[d][S-1];
        rise    = lvl & ~m_hist[d][S];
        elig    = m_gie[d] ? (m_pend[d] & m_mask[d]) : '0;
        take_ok = (m_state[d] == PEND) && int_take[d];
        for (int c = 0; c < N; c++) begin
            if (edge_m[d][c]) np[c] = rise[c] | (m_pend[d][c] & !(take_ok && m_act[d] == c));
            else              np[c] = lvl[c];
        end
        if (m_state[d] == IDLE && elig != 0) begin
            m_act[d]   = pick(d, elig);
            m_vec[d]   = BASE + AW'(m_act[d] * STRIDE);
            m_req[d]   = 1'b1;
            m_state[d] = PEND;
        end else if (take_ok) begin
            m_epc[d] = epc_in[d]; m_gie[d] = 1'b0; m_req[d] = 1'b0; m_insvc[d] = 1'b1;
            m_state[d] = SVC;
        end else if (m_state[d] == SVC && rfe[d]) begin
            m_gie[d] = 1'b1; m_insvc[d] = 1'b0; m_ptr[d] = (m_act[d] + 1) % N;
            m_state[d] = IDLE;
        end
        if (mask_we[d]) m_mask[d] = mask_wdata[d];
        m_pend[d] = np;
        for (int j = S; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
        m_hist[d][0] = irq[d];
    endtask

    task automatic check(input string name, input int d, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) model_reset(d);
            else      model_step(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("m_int_req",    d, AW'(int_req[d]),    AW'(m_req[d]));
            check("m_int_vector", d, int_vector[d],      m_vec[d]);
            check("m_active_ch",  d, AW'(active_ch[d]),  AW'(m_act[d]));
            check("m_epc_out",    d, epc_out[d],         m_epc[d]);
            check("m_in_service", d, AW'(in_service[d]), AW'(m_insvc[d]));
            check("m_mask_q",     d, AW'(mask_q[d]),     AW'(m_mask[d]));
            check("m_pending_q",  d, AW'(pending_q[d]),  AW'(m_pend[d]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_take(input int d, input logic [AW-1:0] pc);
        int_take[d] = 1'b1; epc_in[d] = pc;
        @(negedge clk);
        int_take[d] = 1'b0;
    endtask

    task automatic pulse_rfe(input int d);
        rfe[d] = 1'b1;
        @(negedge clk);
        rfe[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            irq[d] = '0; mask_we[d] = 1'b0; mask_wdata[d] = '0;
            int_take[d] = 1'b0; epc_in[d] = '0; rfe[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_int_req", d, AW'(int_req[d]), 0);
            check("rst_vector",  d, int_vector[d], 32'h100);
            check("rst_mask",    d, AW'(mask_q[d]), 32'hf);
            check("rst_pending", d, AW'(pending_q[d]), 0);
            check("rst_epc",     d, epc_out[d], 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single edge on ch2: request rises after edge k+3
        irq[0][2] = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_early", 0, AW'(int_req[0]), 0);
        @(negedge clk);
        check("lat_req",    0, AW'(int_req[0]), 1);
        check("ch2_vector", 0, int_vector[0], 32'h120);
        check("ch2_active", 0, AW'(active_ch[0]), 2);
        pulse_take(0, 32'h40);
        check("take_req",   0, AW'(int_req[0]), 0);
        check("take_epc",   0, epc_out[0], 32'h40);
        check("take_insvc", 0, AW'(in_service[0]), 1);
        check("take_pend2", 0, AW'(pending_q[0][2]), 0);
        pulse_rfe(0);
        check("rfe_insvc",  0, AW'(in_service[0]), 0);
        irq[0] = '0;
        repeat (4) @(negedge clk);

        // fixed priority: ch1 and ch3 together
        irq[0] = 4'b1010;
        repeat (4) @(negedge clk);
        check("prio_first", 0, int_vector[0], 32'h110);
        pulse_take(0, 32'h44);
        pulse_rfe(0);
        @(negedge clk);
        check("prio_second_req", 0, AW'(int_req[0]), 1);
        check("prio_second",     0, int_vector[0], 32'h130);
        pulse_take(0, 32'h48);
        pulse_rfe(0);
        irq[0] = '0;
        repeat (4) @(negedge clk);

        // masking
        mask_we[0] = 1'b1; mask_wdata[0] = 4'b1011;
        @(negedge clk);
        mask_we[0] = 1'b0;
        irq[0][2] = 1'b1;
        repeat (5) @(negedge clk);
        check("mask_pend", 0, AW'(pending_q[0][2]), 1);
        check("mask_noreq", 0, AW'(int_req[0]), 0);
        mask_we[0] = 1'b1; mask_wdata[0] = 4'b1111;
        @(negedge clk);
        mask_we[0] = 1'b0;
        check("unmask_req1", 0, AW'(int_req[0]), 0);
        @(negedge clk);
        check("unmask_req2", 0, AW'(int_req[0]), 1);
        check("unmask_vec",  0, int_vector[0], 32'h120);
        pulse_take(0, 32'h50);
        pulse_rfe(0);
        irq[0] = '0;
        repeat (4) @(negedge clk);

        // race: new ch2 edge lands on the same edge as its take
        irq[0][2] = 1'b1;
        repeat (4) @(negedge clk);
        check("race_req", 0, AW'(int_req[0]), 1);
        irq[0][2] = 1'b0;
        repeat (4) @(negedge clk);
        irq[0][2] = 1'b1;
        repeat (2) @(negedge clk);
        pulse_take(0, 32'h60);
        check("race_pend2", 0, AW'(pending_q[0][2]), 1);
        check("race_insvc", 0, AW'(in_service[0]), 1);
        // no nesting
        irq[0][0] = 1'b1;
        repeat (4) @(negedge clk);
        check("nest_noreq", 0, AW'(int_req[0]), 0);
        pulse_rfe(0);
        check("rfe_noreq", 0, AW'(int_req[0]), 0);
        @(negedge clk);
        check("rfe_req",    0, AW'(int_req[0]), 1);
        check("rfe_vector", 0, int_vector[0], 32'h100);
        pulse_take(0, 32'h70);

        // reset in SERVICE
        check("pre_rst_insvc", 0, AW'(in_service[0]), 1);
        rst = 1'b0; irq[0] = '0;
        #1;
        check("arst_req",     0, AW'(int_req[0]), 0);
        check("arst_insvc",   0, AW'(in_service[0]), 0);
        check("arst_mask",    0, AW'(mask_q[0]), 32'hf);
        check("arst_pending", 0, AW'(pending_q[0]), 0);
        check("arst_epc",     0, epc_out[0], 0);
        check("arst_active",  0, AW'(active_ch[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // round-robin with level channels 0 and 1 held high
        irq[1] = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            while (!int_req[1] && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rr_req",   1, AW'(int_req[1]), 1);
            check("rr_order", 1, AW'(active_ch[1]), AW'(i % 2));
            pulse_take(1, AW'(32'h200 + i));
            pulse_rfe(1);
        end
        irq[1] = '0;
        repeat (4) @(negedge clk);

        // randomized traffic on both instances
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 699) != 0);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 5) == 0) irq[d] = irq[d] ^ N'(1 << $urandom_range(0, N-1));
                int_take[d]   = int_req[d] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
                epc_in[d]     = $urandom;
                rfe[d]        = ($urandom_range(0, 5) == 0);
                mask_we[d]    = ($urandom_range(0, 31) == 0);
                mask_wdata[d] = N'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            int_take[d] = 1'b0; rfe[d] = 1'b0; mask_we[d] = 1'b0;
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
